// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel programmable clock divider.
package clk_div_pkg;

    // Default width of the high/low/wait count fields.
    localparam int unsigned CNT_W_DEF = 32;

    // Per-channel FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    // Lowest bit index of channel idx inside a flattened per-channel bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// Single divider channel: shadow/active config, phase FSM and down-counter.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_wait,
    input  logic             cfg_load,
    input  logic             start,
    input  logic             ch_en,
    output logic             clk_out,
    output logic             running,
    output logic             cfg_pending
);

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] act_low_q, act_low_d;
    logic [CNT_W-1:0] shd_high_q, shd_high_d;
    logic [CNT_W-1:0] shd_low_q, shd_low_d;
    logic [CNT_W-1:0] shd_wt_q, shd_wt_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             running_q, running_d;

    logic             new_period;
    logic             boundary;
    logic [CNT_W-1:0] per_high;
    logic [CNT_W-1:0] per_low;

    // Next-state: shadow capture, start/resync, phase sequencing and boundary updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_high_d = act_high_q;
        act_low_d  = act_low_q;
        shd_high_d = shd_high_q;
        shd_low_d  = shd_low_q;
        shd_wt_d   = shd_wt_q;
        pend_d     = pend_q;
        new_period = 1'b0;
        boundary   = 1'b0;
        per_high   = act_high_q;
        per_low    = act_low_q;

        if (cfg_load) begin
            shd_high_d = cfg_high;
            shd_low_d  = cfg_low;
            shd_wt_d   = cfg_wait;
            pend_d     = 1'b1;
        end

        if (start && ch_en) begin
            // Start sees this cycle's load (bypass) and always applies the shadow.
            act_high_d = shd_high_d;
            act_low_d  = shd_low_d;
            pend_d     = 1'b0;
            per_high   = shd_high_d;
            per_low    = shd_low_d;
            if ((shd_wt_d != ZERO) && ((shd_high_d != ZERO) || (shd_low_d != ZERO))) begin
                state_d = ST_WAIT;
                cnt_d   = shd_wt_d - ONE;
            end else begin
                new_period = 1'b1;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (!ch_en) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == ZERO) begin
                        new_period = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_HIGH: begin
                    // A high phase always runs to completion, even when disabled.
                    if (cnt_q != ZERO) begin
                        cnt_d = cnt_q - ONE;
                    end else if (!ch_en) begin
                        state_d = ST_IDLE;
                    end else if (act_low_q != ZERO) begin
                        state_d = ST_LOW;
                        cnt_d   = act_low_q - ONE;
                    end else begin
                        boundary = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!ch_en) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q != ZERO) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        boundary = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Period boundary: the only place a pending shadow reaches the active set.
            if (boundary) begin
                new_period = 1'b1;
                if (pend_q) begin
                    act_high_d = shd_high_q;
                    act_low_d  = shd_low_q;
                    per_high   = shd_high_q;
                    per_low    = shd_low_q;
                    pend_d     = cfg_load;
                end
            end
        end

        // Enter a fresh period, skipping any zero-length phase.
        if (new_period) begin
            if (per_high != ZERO) begin
                state_d = ST_HIGH;
                cnt_d   = per_high - ONE;
            end else if (per_low != ZERO) begin
                state_d = ST_LOW;
                cnt_d   = per_low - ONE;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = ZERO;
            end
        end

        clk_out_d = (state_d == ST_HIGH);
        running_d = (state_d != ST_IDLE);
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= ZERO;
            act_high_q <= ZERO;
            act_low_q  <= ZERO;
            shd_high_q <= ZERO;
            shd_low_q  <= ZERO;
            shd_wt_q   <= ZERO;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_high_q <= act_high_d;
            act_low_q  <= act_low_d;
            shd_high_q <= shd_high_d;
            shd_low_q  <= shd_low_d;
            shd_wt_q   <= shd_wt_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            running_q  <= running_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign running     = running_q;
    assign cfg_pending = pend_q;

endmodule

// File: rtl/multi_clk_divider.sv
// N_CH independent programmable clock dividers sharing one start strobe.
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*CNT_W-1:0] cfg_high,
    input  logic [N_CH*CNT_W-1:0] cfg_low,
    input  logic [N_CH*CNT_W-1:0] cfg_wait,
    input  logic [N_CH-1:0]       cfg_load,
    input  logic                  start,
    input  logic [N_CH-1:0]       ch_en,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       cfg_pending
);

    // One channel per bus slice.
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        localparam int unsigned LO = slice_lo(g, CNT_W);

        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cfg_high    (cfg_high[LO +: CNT_W]),
            .cfg_low     (cfg_low[LO +: CNT_W]),
            .cfg_wait    (cfg_wait[LO +: CNT_W]),
            .cfg_load    (cfg_load[g]),
            .start       (start),
            .ch_en       (ch_en[g]),
            .clk_out     (clk_out[g]),
            .running     (running[g]),
            .cfg_pending (cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: directed scenarios then random traffic, checked
// against a position-in-period reference model of every channel.
module tb_multi_clk_divider;

    localparam int unsigned N = 6;
    localparam int unsigned W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   cfg_high, cfg_low, cfg_wait;
    logic [N-1:0]     cfg_load, ch_en;
    logic             start;
    logic [N-1:0]     clk_out, running, cfg_pending;

    multi_clk_divider #(.N_CH(N), .CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .cfg_wait    (cfg_wait),
        .cfg_load    (cfg_load),
        .start       (start),
        .ch_en       (ch_en),
        .clk_out     (clk_out),
        .running     (running),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    // Reference model: active/shadow values, run flag, and the edge index t0 at
    // which the current period's first cycle begins (waiting = negative position).
    longint a_h[N], a_l[N];
    longint s_h[N], s_l[N], s_w[N];
    bit     m_run[N], m_pend[N];
    longint m_t0[N];
    longint n;
    int     n_cmp, n_err;

    task automatic set_cfg(input int ch, input int h, input int l, input int w);
        cfg_high[ch*W +: W] = W'(h);
        cfg_low[ch*W +: W]  = W'(l);
        cfg_wait[ch*W +: W] = W'(w);
        cfg_load[ch]        = 1'b1;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit     op;
            longint oh, ol, q;
            if (rst) begin
                a_h[i] = 0; a_l[i] = 0;
                s_h[i] = 0; s_l[i] = 0; s_w[i] = 0;
                m_run[i] = 0; m_pend[i] = 0; m_t0[i] = 0;
            end else begin
                op = m_pend[i];
                oh = s_h[i];
                ol = s_l[i];
                if (cfg_load[i]) begin
                    s_h[i] = longint'(cfg_high[i*W +: W]);
                    s_l[i] = longint'(cfg_low[i*W +: W]);
                    s_w[i] = longint'(cfg_wait[i*W +: W]);
                    m_pend[i] = 1;
                end
                if (start && ch_en[i]) begin
                    a_h[i] = s_h[i];
                    a_l[i] = s_l[i];
                    m_pend[i] = 0;
                    m_run[i] = (a_h[i] + a_l[i]) != 0;
                    m_t0[i] = n + s_w[i];
                end else if (m_run[i]) begin
                    q = n - m_t0[i];
                    if (q == a_h[i] + a_l[i]) begin
                        if (!ch_en[i]) begin
                            m_run[i] = 0;
                        end else begin
                            if (op) begin
                                a_h[i] = oh;
                                a_l[i] = ol;
                                m_pend[i] = cfg_load[i];
                            end
                            m_t0[i] = n;
                            if (a_h[i] + a_l[i] == 0) m_run[i] = 0;
                        end
                    end else if (!ch_en[i] && !(q >= 1 && q < a_h[i])) begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            longint q;
            logic   exp_c, exp_r, exp_p;
            q     = n - m_t0[i];
            exp_c = m_run[i] && (q >= 0) && (q < a_h[i]);
            exp_r = m_run[i];
            exp_p = m_pend[i];
            n_cmp++;
            assert (clk_out[i] === exp_c) else begin
                n_err++;
                $error("FAIL clk_out[%0d] edge %0d: observed %b expected %b", i, n, clk_out[i], exp_c);
            end
            n_cmp++;
            assert (running[i] === exp_r) else begin
                n_err++;
                $error("FAIL running[%0d] edge %0d: observed %b expected %b", i, n, running[i], exp_r);
            end
            n_cmp++;
            assert (cfg_pending[i] === exp_p) else begin
                n_err++;
                $error("FAIL cfg_pending[%0d] edge %0d: observed %b expected %b", i, n, cfg_pending[i], exp_p);
            end
        end
    endtask

    // One clock: model and DUT see the same inputs at the edge; outputs checked 1 unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        n++;
        cfg_load = '0;
        start    = 1'b0;
    endtask

    task automatic steps(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    initial begin
        n = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; cfg_load = '0; ch_en = '0;
        cfg_high = '0; cfg_low = '0; cfg_wait = '0;
        steps(2);
        rst = 1'b0;
        steps(2);

        // Basic: H=2 L=3 W=0 on channel 0.
        ch_en = 6'b000001;
        set_cfg(0, 2, 3, 0); start = 1'b1; step();
        steps(15);

        // Alignment: ch1 waits 4, ch2 starts immediately, same strobe.
        ch_en = 6'b000111;
        set_cfg(1, 1, 1, 4); set_cfg(2, 1, 1, 0); step();
        start = 1'b1; step();
        steps(12);

        // Glitch-free update mid-HIGH.
        ch_en = 6'b000001;
        set_cfg(0, 4, 4, 0); start = 1'b1; step();
        steps(2);
        set_cfg(0, 1, 1, 0); step();
        steps(16);

        // Disable on the second high cycle of a 5-cycle high phase.
        set_cfg(0, 5, 2, 0); start = 1'b1; step();
        step();
        ch_en[0] = 1'b0;
        steps(8);

        // Synchronous reset mid-run, then idle until a new load+start.
        ch_en[0] = 1'b1;
        set_cfg(0, 3, 2, 0); start = 1'b1; step();
        step();
        rst = 1'b1; step();
        rst = 1'b0; steps(3);
        start = 1'b1; step();
        steps(3);

        // Degenerate settings: 0/0 ignored, 0/7 constant low, 6/0 constant high.
        ch_en = 6'b111000;
        set_cfg(3, 0, 0, 0); set_cfg(4, 0, 7, 0); set_cfg(5, 6, 0, 2);
        start = 1'b1; step();
        steps(20);

        // Identical config on two channels from one strobe.
        ch_en = 6'b011000;
        set_cfg(3, 3, 2, 1); set_cfg(4, 3, 2, 1); start = 1'b1; step();
        steps(12);

        // Full-scale high time.
        ch_en = 6'b100000;
        set_cfg(5, 255, 3, 1); start = 1'b1; step();
        steps(265);
        ch_en = '0;
        steps(3);

        // Random traffic.
        ch_en = '1;
        for (int r = 0; r < 3000; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
                if ($urandom_range(0, 7) == 0)
                    set_cfg(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                            int'($urandom_range(0, 3)));
            end
            start = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- N_CH-channel programmable clock divider driven from the single system clock `clk`.
- Each channel produces a square-ish output with a programmable high time, low time and start delay, all counted in `clk` cycles.
- Adds shadowed configuration with glitch-free period-boundary updates, a common synchronous start for phase alignment, graceful per-channel disable, and defined degenerate-setting behaviour.
- Config buses are fed from host wire-in endpoints; outputs drive test I/O pins.

Parameters:
- N_CH, 6, number of independent divider channels.
- CNT_W, 32, width of the high/low/wait count fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_high  in  N_CH*CNT_W  per-channel high-phase length in cycles; channel i at [i*CNT_W +: CNT_W].
- cfg_low  in  N_CH*CNT_W  per-channel low-phase length in cycles.
- cfg_wait  in  N_CH*CNT_W  per-channel delay from start to first rising edge.
- cfg_load  in  N_CH  one-cycle strobe per channel; captures that channel's cfg_* slices into shadow.
- start  in  1  one-cycle strobe; (re)starts all enabled channels together.
- ch_en  in  N_CH  per-channel enable level.
- clk_out  out  N_CH  registered divided outputs.
- running  out  N_CH  channel in WAIT/HIGH/LOW.
- cfg_pending  out  N_CH  shadow holds values not yet applied.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - clk_out=0, running=0, cfg_pending=0.
  - All channels to IDLE; active and shadow registers cleared to 0.
  - Reset asserted mid-operation forces this state at the next edge.
- Per-channel FSM states: IDLE, WAIT, HIGH, LOW. `running` = (state != IDLE), registered.
- cfg_load[i]:
  - Shadow <= slices and pending <= 1.
  - A load while already pending overwrites the shadow; pending stays 1.
- Shadow-to-active copy occurs only at:
  - (a) start acceptance;
  - (b) LOW-to-HIGH transition (period boundary) when pending=1.
  - pending clears on the copy.
  - Active values never change mid-period.
- Same-cycle cfg_load[i] and start: start uses the values being loaded (bypass); pending ends 0.
- start accepted for channel i when ch_en[i]=1, from any state (resync):
  - If active high==0 and low==0 (after copy), start is ignored and channel goes or stays IDLE.
  - Otherwise, with W = wait:
    - W==0: enter HIGH; clk_out=1 after the same edge.
    - W>0: enter WAIT for exactly W cycles; clk_out rises after edge k+W, where k is the start edge.
- Steady state: clk_out=1 for exactly H cycles, then 0 for exactly L cycles, repeating; period H+L.
  - H==0, L>0: clk_out held 0 while running (HIGH skipped).
  - L==0, H>0: clk_out held 1 while running.
- Counters: down-counters loaded with value-1, CNT_W bits, no wrap. Full-scale 2^CNT_W-1 must work.
- ch_en[i] deasserted:
  - In WAIT or LOW: IDLE at next edge.
  - In HIGH: completes the remaining high cycles, then IDLE. No runt pulse.
  - clk_out=0 in IDLE.
- start with ch_en[i]=0 has no effect on channel i.
- Channels are fully independent apart from the shared start.
- Two channels with identical config started by the same strobe produce cycle-identical outputs.

Decomposition:
- Shared package `clk_div_pkg`: state enum (IDLE, WAIT, HIGH, LOW), default CNT_W, slice-index helper function.
- One sub-module `clk_div_chan`: single-channel FSM, counters, shadow/active registers.
- Top-level generate-loop instantiates N_CH copies and slices the buses.

Test Plan:
- Reset values: after rst → all clk_out, running and cfg_pending are 0. Assert rst for 1 cycle mid-run with H=3 → outputs 0 next edge; channel stays IDLE until a new load+start.
- Basic: ch0 load H=2, L=3, W=0; start at edge k → clk_out0 high for edges k..k+1, low for k+2..k+4, period 5, repeating.
- Alignment: ch1 W=4 and ch2 W=0, both H=L=1, single start → ch2 toggles immediately; ch1 first rises exactly 4 cycles later; `running` asserts on both after the start edge.
- Glitch-free update: ch0 running H=4, L=4; cfg_load H=1, L=1 mid-HIGH → current HIGH stays 4 cycles and LOW stays 4; pending=1 until the boundary, then 1/1 toggling.
- Disable during HIGH: H=5, ch_en drops on 2nd high cycle → clk_out stays high 5 cycles total, then 0; running=0 afterwards.
- Degenerate settings: H=0, L=0 → start ignored, running stays 0. H=0, L=7 → clk_out constant 0 with running=1. H=6, L=0 → constant 1. Full-scale H=2^CNT_W-1 (CNT_W=8 bench) → 255 high cycles.
